// File: rtl/led_pkg.sv
// Shared mode encoding for the LED pattern controller.
package led_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_BLINK  = 2'd0;
    localparam mode_t MODE_CHASE  = 2'd1;
    localparam mode_t MODE_BOUNCE = 2'd2;
    localparam mode_t MODE_COUNT  = 2'd3;

endpackage

// File: rtl/step_timer.sv
// Step-rate timer: a prescaler producing unit ticks, and a unit counter that
// fires step_en once it has counted past the current delay.
module step_timer #(
    parameter int unsigned TICK_BASE = 3_125_000,
    parameter int unsigned DELAY_W   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               hold,
    input  logic [DELAY_W-1:0] delay,
    output logic               step_en
);

    localparam int unsigned PRESC_W = (TICK_BASE > 1) ? $clog2(TICK_BASE) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_BASE - 1);

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [DELAY_W-1:0] unit_q, unit_d;
    logic               unit_tick;

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
            unit_q  <= '0;
        end else begin
            presc_q <= presc_d;
            unit_q  <= unit_d;
        end
    end

    // >= rather than == so a delay lowered below the running count fires on the next tick
    always_comb begin
        presc_d   = presc_q;
        unit_d    = unit_q;
        unit_tick = 1'b0;
        step_en   = 1'b0;
        if (clear) begin
            presc_d = '0;
            unit_d  = '0;
        end else if (!hold) begin
            if (presc_q == PRESC_MAX) begin
                presc_d   = '0;
                unit_tick = 1'b1;
            end else begin
                presc_d = presc_q + PRESC_W'(1);
            end
            if (unit_tick) begin
                if (unit_q >= delay) begin
                    unit_d  = '0;
                    step_en = 1'b1;
                end else begin
                    unit_d = unit_q + DELAY_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/led_pattern_ctrl.sv
// Multi-pattern LED driver: blink, chase, bounce and binary count at a
// pulse-adjustable step rate, with pause and mode cycling.
module led_pattern_ctrl
    import led_pkg::*;
#(
    parameter int unsigned N_LED      = 4,
    parameter int unsigned TICK_BASE  = 3_125_000,
    parameter int unsigned DELAY_W    = 4,
    parameter int unsigned DELAY_INIT = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               faster,
    input  logic               slower,
    input  logic               pause,
    input  logic               mode_next,
    output logic [N_LED-1:0]   led,
    output logic [DELAY_W-1:0] delay,
    output logic [1:0]         mode,
    output logic               paused,
    output logic               step
);

    localparam logic [DELAY_W-1:0] DELAY_RST = DELAY_W'(DELAY_INIT);

    logic [N_LED-1:0]   led_q, led_d, bounce_nxt;
    logic [DELAY_W-1:0] delay_q, delay_d;
    mode_t              mode_q, mode_d;
    logic               paused_q, paused_d;
    logic               dir_up_q, dir_up_d;
    logic               step_q, step_d;
    logic               step_en;

    step_timer #(
        .TICK_BASE (TICK_BASE),
        .DELAY_W   (DELAY_W)
    ) u_step_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (mode_next),
        .hold    (paused_q),
        .delay   (delay_q),
        .step_en (step_en)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            led_q    <= '1;
            delay_q  <= DELAY_RST;
            mode_q   <= MODE_BLINK;
            paused_q <= 1'b0;
            dir_up_q <= 1'b1;
            step_q   <= 1'b0;
        end else begin
            led_q    <= led_d;
            delay_q  <= delay_d;
            mode_q   <= mode_d;
            paused_q <= paused_d;
            dir_up_q <= dir_up_d;
            step_q   <= step_d;
        end
    end

    always_comb begin
        delay_d    = delay_q;
        mode_d     = mode_q;
        paused_d   = paused_q;
        led_d      = led_q;
        dir_up_d   = dir_up_q;
        step_d     = 1'b0;
        bounce_nxt = led_q;

        if (faster && !slower && (delay_q != '0)) begin
            delay_d = delay_q - DELAY_W'(1);
        end else if (slower && !faster && (delay_q != '1)) begin
            delay_d = delay_q + DELAY_W'(1);
        end

        if (pause) begin
            paused_d = !paused_q;
        end

        // A mode change pre-empts any step due on the same edge
        if (mode_next) begin
            mode_d   = mode_q + 2'd1;
            dir_up_d = 1'b1;
            case (mode_d)
                MODE_BLINK: led_d = '1;
                MODE_COUNT: led_d = '0;
                default:    led_d = N_LED'(1);
            endcase
        end else if (step_en) begin
            step_d = 1'b1;
            case (mode_q)
                MODE_BLINK: led_d = ~led_q;
                MODE_CHASE: led_d = (led_q << 1) | (led_q >> (N_LED - 1));
                MODE_BOUNCE: begin
                    if (N_LED == 1) begin
                        bounce_nxt = led_q;
                    end else if (dir_up_q) begin
                        bounce_nxt = led_q << 1;
                        dir_up_d   = !bounce_nxt[N_LED-1];
                    end else begin
                        bounce_nxt = led_q >> 1;
                        dir_up_d   = bounce_nxt[0];
                    end
                    led_d = bounce_nxt;
                end
                default: led_d = led_q + N_LED'(1);
            endcase
        end
    end

    assign led    = led_q;
    assign delay  = delay_q;
    assign mode   = mode_q;
    assign paused = paused_q;
    assign step   = step_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Vector-table bench for led_pattern_ctrl: each record pulses inputs, waits a
// fixed number of cycles, then checks all outputs against a queued expectation.
module tb_led_pattern_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       faster = 1'b0;
    logic       slower = 1'b0;
    logic       pause = 1'b0;
    logic       mode_next = 1'b0;
    logic [3:0] led;
    logic [2:0] delay;
    logic [1:0] mode;
    logic       paused;
    logic       step;

    led_pattern_ctrl #(
        .N_LED      (4),
        .TICK_BASE  (4),
        .DELAY_W    (3),
        .DELAY_INIT (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .faster    (faster),
        .slower    (slower),
        .pause     (pause),
        .mode_next (mode_next),
        .led       (led),
        .delay     (delay),
        .mode      (mode),
        .paused    (paused),
        .step      (step)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        f, s, p, m, r;
        int unsigned cycles;
        logic [3:0]  led;
        logic [2:0]  delay;
        logic [1:0]  mode;
        logic        paused;
        logic        step;
    } vec_t;

    typedef struct {
        string       name;
        logic [10:0] outs;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic void add(input string name, input logic f, input logic s,
                                input logic p, input logic m, input logic r,
                                input int unsigned cyc, input logic [3:0] l,
                                input logic [2:0] d, input logic [1:0] md,
                                input logic pz, input logic st);
        vec_t v;
        v.name = name; v.f = f; v.s = s; v.p = p; v.m = m; v.r = r;
        v.cycles = cyc; v.led = l; v.delay = d; v.mode = md;
        v.paused = pz; v.step = st;
        vecs.push_back(v);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_head();
        exp_t        e;
        logic [10:0] act;
        e   = sb.pop_front();
        act = {led, delay, mode, paused, step};
        n_vec++;
        if (act !== e.outs) begin
            n_err++;
            $display("FAIL %s @%0t: got led=%b delay=%0d mode=%0d paused=%b step=%b, want led=%b delay=%0d mode=%0d paused=%b step=%b",
                     e.name, $time, act[10:7], act[6:4], act[3:2], act[1], act[0],
                     e.outs[10:7], e.outs[6:4], e.outs[3:2], e.outs[1], e.outs[0]);
        end
    endtask

    task automatic apply(input vec_t v);
        exp_t e;
        e.name = v.name;
        e.outs = {v.led, v.delay, v.mode, v.paused, v.step};
        if (v.cycles > 0) begin
            reset = v.r; faster = v.f; slower = v.s; pause = v.p; mode_next = v.m;
        end
        sb.push_back(e);
        if (v.cycles > 0) begin
            cyc();
            reset = 1'b0; faster = 1'b0; slower = 1'b0; pause = 1'b0; mode_next = 1'b0;
            repeat (v.cycles - 1) cyc();
        end
        check_head();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
        $fatal(1);
    end

    initial begin
        // Reset release and default blink timing (period 12 cycles)
        add("rst_state",    0,0,0,0,0,  0, 4'hF, 3'd2, 2'd0, 0, 0);
        add("pre_step",     0,0,0,0,0, 11, 4'hF, 3'd2, 2'd0, 0, 0);
        add("first_step",   0,0,0,0,0,  1, 4'h0, 3'd2, 2'd0, 0, 1);
        add("step_pulse",   0,0,0,0,0,  1, 4'h0, 3'd2, 2'd0, 0, 0);
        add("second_step",  0,0,0,0,0, 11, 4'hF, 3'd2, 2'd0, 0, 1);
        // faster saturates at 0; lowered delay fires on the next unit tick
        add("faster1",      1,0,0,0,0,  1, 4'hF, 3'd1, 2'd0, 0, 0);
        add("faster2",      1,0,0,0,0,  1, 4'hF, 3'd0, 2'd0, 0, 0);
        add("faster3_sat",  1,0,0,0,0,  1, 4'hF, 3'd0, 2'd0, 0, 0);
        add("faster4_step", 1,0,0,0,0,  1, 4'h0, 3'd0, 2'd0, 0, 1);
        add("faster5",      1,0,0,0,0,  1, 4'h0, 3'd0, 2'd0, 0, 0);
        add("fast_step_a",  0,0,0,0,0,  3, 4'hF, 3'd0, 2'd0, 0, 1);
        add("fast_step_b",  0,0,0,0,0,  4, 4'h0, 3'd0, 2'd0, 0, 1);
        add("fast_gap",     0,0,0,0,0,  3, 4'h0, 3'd0, 2'd0, 0, 0);
        add("fast_step_c",  0,0,0,0,0,  1, 4'hF, 3'd0, 2'd0, 0, 1);
        for (int k = 1; k <= 10; k++)
            add("slower", 0,1,0,0,0, 1, 4'hF, (k >= 7) ? 3'd7 : 3'(k), 2'd0, 0, 0);
        add("slow_pre",     0,0,0,0,0, 21, 4'hF, 3'd7, 2'd0, 0, 0);
        add("slow_step_a",  0,0,0,0,0,  1, 4'h0, 3'd7, 2'd0, 0, 1);
        add("slow_gap",     0,0,0,0,0, 31, 4'h0, 3'd7, 2'd0, 0, 0);
        add("slow_step_b",  0,0,0,0,0,  1, 4'hF, 3'd7, 2'd0, 0, 1);
        add("fast_and_slow",1,1,0,0,0,  1, 4'hF, 3'd7, 2'd0, 0, 0);
        // Chase
        add("to_chase",     0,0,0,1,0,  1, 4'h1, 3'd7, 2'd1, 0, 0);
        add("chase_gap",    0,0,0,0,0, 31, 4'h1, 3'd7, 2'd1, 0, 0);
        add("chase_0010",   0,0,0,0,0,  1, 4'h2, 3'd7, 2'd1, 0, 1);
        add("chase_0100",   0,0,0,0,0, 32, 4'h4, 3'd7, 2'd1, 0, 1);
        add("chase_1000",   0,0,0,0,0, 32, 4'h8, 3'd7, 2'd1, 0, 1);
        add("chase_wrap",   0,0,0,0,0, 32, 4'h1, 3'd7, 2'd1, 0, 1);
        for (int k = 1; k <= 7; k++)
            add("chase_faster", 1,0,0,0,0, 1, 4'h1, 3'(7 - k), 2'd1, 0, 0);
        add("chase_fast",   0,0,0,0,0,  1, 4'h2, 3'd0, 2'd1, 0, 1);
        // Bounce then count
        add("to_bounce",    0,0,0,1,0,  1, 4'h1, 3'd0, 2'd2, 0, 0);
        add("bounce_0010",  0,0,0,0,0,  4, 4'h2, 3'd0, 2'd2, 0, 1);
        add("bounce_0100",  0,0,0,0,0,  4, 4'h4, 3'd0, 2'd2, 0, 1);
        add("bounce_1000",  0,0,0,0,0,  4, 4'h8, 3'd0, 2'd2, 0, 1);
        add("bounce_dn100", 0,0,0,0,0,  4, 4'h4, 3'd0, 2'd2, 0, 1);
        add("bounce_dn010", 0,0,0,0,0,  4, 4'h2, 3'd0, 2'd2, 0, 1);
        add("bounce_dn001", 0,0,0,0,0,  4, 4'h1, 3'd0, 2'd2, 0, 1);
        add("bounce_up010", 0,0,0,0,0,  4, 4'h2, 3'd0, 2'd2, 0, 1);
        add("to_count",     0,0,0,1,0,  1, 4'h0, 3'd0, 2'd3, 0, 0);
        for (int k = 1; k <= 16; k++)
            add("count_step", 0,0,0,0,0, 4, 4'(k), 3'd0, 2'd3, 0, 1);
        add("wrap_to_blink",0,0,0,1,0,  1, 4'hF, 3'd0, 2'd0, 0, 0);
        // Pause mid-period, with delay edits while paused
        add("p_slower1",    0,1,0,0,0,  1, 4'hF, 3'd1, 2'd0, 0, 0);
        add("p_slower2",    0,1,0,0,0,  1, 4'hF, 3'd2, 2'd0, 0, 0);
        add("p_slower3",    0,1,0,0,0,  1, 4'hF, 3'd3, 2'd0, 0, 0);
        add("p_step",       0,0,0,0,0, 13, 4'h0, 3'd3, 2'd0, 0, 1);
        add("p_mid",        0,0,0,0,0,  5, 4'h0, 3'd3, 2'd0, 0, 0);
        add("pause_on",     0,0,1,0,0,  1, 4'h0, 3'd3, 2'd0, 1, 0);
        add("paused_hold",  0,0,0,0,0, 41, 4'h0, 3'd3, 2'd0, 1, 0);
        add("paused_slow",  0,1,0,0,0,  1, 4'h0, 3'd4, 2'd0, 1, 0);
        add("paused_fast",  1,0,0,0,0,  1, 4'h0, 3'd3, 2'd0, 1, 0);
        add("paused_hold2", 0,0,0,0,0, 57, 4'h0, 3'd3, 2'd0, 1, 0);
        add("pause_off",    0,0,1,0,0,  1, 4'h0, 3'd3, 2'd0, 0, 0);
        add("resume_gap",   0,0,0,0,0,  9, 4'h0, 3'd3, 2'd0, 0, 0);
        add("resume_step",  0,0,0,0,0,  1, 4'hF, 3'd3, 2'd0, 0, 1);
        // mode_next on a due step, pause+mode_next together, reset priority
        add("due_pre",      0,0,0,0,0, 15, 4'hF, 3'd3, 2'd0, 0, 0);
        add("mode_on_step", 0,0,0,1,0,  1, 4'h1, 3'd3, 2'd1, 0, 0);
        add("cleared_gap",  0,0,0,0,0, 15, 4'h1, 3'd3, 2'd1, 0, 0);
        add("cleared_step", 0,0,0,0,0,  1, 4'h2, 3'd3, 2'd1, 0, 1);
        add("pause_and_mode",0,0,1,1,0, 1, 4'h1, 3'd3, 2'd2, 1, 0);
        add("pm_hold",      0,0,0,0,0, 20, 4'h1, 3'd3, 2'd2, 1, 0);
        add("pm_unpause",   0,0,1,0,0,  1, 4'h1, 3'd3, 2'd2, 0, 0);
        add("pm_gap",       0,0,0,0,0, 15, 4'h1, 3'd3, 2'd2, 0, 0);
        add("pm_step",      0,0,0,0,0,  1, 4'h2, 3'd3, 2'd2, 0, 1);
        add("pre_reset",    0,0,0,0,0,  5, 4'h2, 3'd3, 2'd2, 0, 0);
        add("reset_prio",   0,1,1,1,1,  1, 4'hF, 3'd2, 2'd0, 0, 0);
        add("post_rst_step",0,0,0,0,0, 12, 4'h0, 3'd2, 2'd0, 0, 1);

        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        foreach (vecs[i]) apply(vecs[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/led_pattern_ctrl.md
Name: led_pattern_ctrl

Overview:
Parametrised successor of the single-pattern LED blinker. It drives N_LED outputs with one of four selectable patterns: blink, chase, bounce and binary count. Step rate is set by a saturating delay register. All control inputs are single-cycle pulses that have already been conditioned by the team's oneshot/debounce stage. The block sits between the key-conditioning logic and the board LED pins, replacing the separate delay_ctrl and blinker pair.

Parameters:
N_LED, 4, number of LED outputs (>=1)
TICK_BASE, 3_125_000, clk cycles per delay unit (>=1)
DELAY_W, 4, width of delay register
DELAY_INIT, 8, delay value after reset (must fit in DELAY_W)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
faster  in  1  1-cycle pulse: decrement delay (shorter period)
slower  in  1  1-cycle pulse: increment delay (longer period)
pause  in  1  1-cycle pulse: toggle paused state
mode_next  in  1  1-cycle pulse: advance to next pattern mode
led  out  N_LED  registered LED pattern
delay  out  DELAY_W  current delay value
mode  out  2  current mode (0 BLINK, 1 CHASE, 2 BOUNCE, 3 COUNT)
paused  out  1  current paused state
step  out  1  1-cycle pulse, high in the first cycle a new led value is visible

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-high; all state is cleared on the clk edge where reset=1.
- Reset values: delay=DELAY_INIT, mode=0, paused=0, led=all ones, step=0, prescaler=0, unit counter=0, bounce dir=up.
- Step period: (delay+1)*TICK_BASE cycles.
  - The prescaler counts 0..TICK_BASE-1 and produces a unit tick on its terminal count.
  - The unit counter increments on each unit tick. When a unit tick occurs with unit counter >= delay, the counter returns to 0 and the pattern advances.
  - led and step both update on that clock edge.
  - First led change after reset release is visible in cycle (DELAY_INIT+1)*TICK_BASE, counting the first non-reset cycle as 0.
- Delay:
  - faster decrements delay, saturating at 0.
  - slower increments delay, saturating at 2^DELAY_W-1.
  - faster and slower in the same cycle: no change.
  - A new delay takes effect immediately and the counters are not cleared. The >= compare guarantees that lowering delay below the current unit count fires on the next unit tick.
- Pause:
  - The pause pulse toggles paused.
  - While paused, prescaler, unit counter, led and direction all hold, and step stays 0.
  - On unpause, counting resumes from the held counts.
  - delay and mode still respond while paused.
- Mode change: mode_next advances mode 0->1->2->3->0. On the same edge:
  - prescaler and unit counter clear to 0;
  - led loads the new mode's seed;
  - direction resets to up;
  - step is not asserted.
  If paused, the new seed is loaded but paused is unchanged.
- Patterns, advanced on each step:
  - BLINK: seed all ones; step inverts all bits.
  - CHASE: seed 1 (bit 0); step rotates left, MSB wraps to bit 0.
  - BOUNCE: seed 1, dir up.
    - Up shifts left; on reaching the MSB, dir flips and the next step shifts right.
    - Down shifts right; on reaching bit 0, dir flips.
    - No bit is repeated at the ends.
    - N_LED=1: led stays 1.
  - COUNT: seed 0; step adds 1 modulo 2^N_LED.
- Simultaneous events:
  - pause and mode_next together: both apply.
  - mode_next coinciding with a step: the mode change wins and no pattern advance occurs.
  - reset has priority over every input.
- Invariant: no combinational path from any input to led.

Decomposition:
- Package led_pkg: mode constants MODE_BLINK=0, MODE_CHASE=1, MODE_BOUNCE=2, MODE_COUNT=3, and a 2-bit mode typedef.
- Sub-module step_timer: the prescaler plus unit counter.
  - Inputs: clk, reset, clear, hold, delay.
  - Output: step_en.
- The top level holds the delay, mode and paused registers and the pattern datapath.

Test Plan:
Bench parameters: TICK_BASE=4, DELAY_W=3, DELAY_INIT=2, N_LED=4.
1. Reset release -> led=1111, delay=2, mode=0, paused=0; led=0000 with step=1 in cycle 12; led=1111 in cycle 24.
2. 5x faster -> delay saturates at 0, step every 4 cycles; 10x slower -> delay=7, step every 32 cycles; faster+slower same cycle -> delay unchanged.
3. 1x mode_next -> mode=1, led=0001 next cycle, counters cleared; subsequent steps 0010, 0100, 1000, 0001.
4. Mode 2 -> steps give 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010; mode 3 -> 0000..1111 then wraps to 0000; mode_next from 3 -> mode 0, led=1111.
5. pause mid-period -> paused=1, led and step frozen for 100 cycles; second pause -> next step occurs after exactly the remaining cycles of the interrupted period.
6. mode_next on the same cycle as a due step -> seed loaded, no advance, step=0; reset asserted mid-pattern -> all reset values on the next cycle.
